// File: rtl/clock_set_pkg.sv
// Shared types and BCD step helpers for the time/date field editor.
//   setter_state_t : editor FSM states (RUN, EDIT, COMMIT)
//   bcd_step_inc   : BCD +1 with [min,max] wrap; invalid input snaps to min
//   bcd_step_dec   : BCD -1 with [min,max] wrap; invalid input snaps to max
package clock_set_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } setter_state_t;

  // A field is usable only if both nibbles are decimal digits and the value
  // sits inside its range. Valid BCD compares correctly as plain binary.
  function automatic logic bcd_valid(input logic [7:0] val,
                                     input logic [7:0] min,
                                     input logic [7:0] max);
    return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) &&
           (val >= min) && (val <= max);
  endfunction

  function automatic logic [7:0] bcd_step_inc(input logic [7:0] val,
                                              input logic [7:0] min,
                                              input logic [7:0] max);
    logic [7:0] r;
    if (!bcd_valid(val, min, max))   r = min;
    else if (val == max)             r = min;
    else if (val[3:0] == 4'd9)       r = {val[7:4] + 4'd1, 4'd0};
    else                             r = val + 8'd1;
    return r;
  endfunction

  function automatic logic [7:0] bcd_step_dec(input logic [7:0] val,
                                              input logic [7:0] min,
                                              input logic [7:0] max);
    logic [7:0] r;
    if (!bcd_valid(val, min, max))   r = max;
    else if (val == min)             r = max;
    else if (val[3:0] == 4'd0)       r = {val[7:4] - 4'd1, 4'd9};
    else                             r = val - 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Hold-to-repeat step generator for one debounced key level.
//   clk, rst_n : clock, asynchronous active-low reset
//   lvl        : debounced key level
//   clr        : restart the repeat timing (no step while asserted)
//   step_p     : one-cycle step pulse
// A step fires on the rising edge of lvl, then on the REPEAT_DLY-th held
// cycle, then every REPEAT_PER held cycles after that.
module key_repeat #(
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  input  logic clr,
  output logic step_p
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic          lvl_q;
  logic          rep_phase;   // 0: waiting out the initial delay, 1: periodic
  logic [CW-1:0] cnt;
  logic          edge_hit;
  logic          dly_hit;
  logic          per_hit;

  assign edge_hit = lvl & ~lvl_q;
  assign dly_hit  = ~rep_phase & (cnt == CW'(REPEAT_DLY - 1));
  assign per_hit  =  rep_phase & (cnt == CW'(REPEAT_PER - 1));
  assign step_p   = lvl & ~clr & (edge_hit | dly_hit | per_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q     <= 1'b0;
      rep_phase <= 1'b0;
      cnt       <= '0;
    end else begin
      lvl_q <= lvl;
      if (clr || !lvl) begin
        rep_phase <= 1'b0;
        cnt       <= '0;
      end else if (dly_hit || per_hit) begin
        rep_phase <= 1'b1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_field_setter.sv
// BCD time/date editor between debounced keys and the clock/calendar counters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   set_p       : enter edit (RUN) / commit (EDIT)
//   sel_p       : advance to next field, wrapping
//   cancel_p    : abort edit without load
//   inc_lvl     : increment key level, auto-repeats while held
//   dec_lvl     : decrement key level, auto-repeats while held
//   cur_val     : live counter value, captured on edit entry
//   set_en      : high in EDIT and COMMIT (counter frozen)
//   set_load    : one-cycle load pulse in COMMIT
//   set_val     : edited value, held outside EDIT
//   blink_mask  : one-hot active field while editing
//   timeout_p   : one-cycle pulse after an inactivity abort
module multi_field_setter
  import clock_set_pkg::*;
#(
  parameter int                      NUM_FIELDS  = 3,
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX   = {8'h59, 8'h59, 8'h23},
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MIN   = {8'h00, 8'h00, 8'h00},
  parameter int                      REPEAT_DLY  = 500,
  parameter int                      REPEAT_PER  = 100,
  parameter int                      TIMEOUT_CYC = 10000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_p,
  input  logic                    sel_p,
  input  logic                    cancel_p,
  input  logic                    inc_lvl,
  input  logic                    dec_lvl,
  input  logic [8*NUM_FIELDS-1:0] cur_val,
  output logic                    set_en,
  output logic                    set_load,
  output logic [8*NUM_FIELDS-1:0] set_val,
  output logic [NUM_FIELDS-1:0]   blink_mask,
  output logic                    timeout_p
);

  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  setter_state_t           state, state_nx;
  logic [FW-1:0]           field_idx, field_idx_nx;
  logic [8*NUM_FIELDS-1:0] set_val_nx;
  logic [TW-1:0]           tcnt, tcnt_nx;
  logic                    timeout_nx;
  logic                    in_edit;
  logic                    rep_clr;
  logic                    inc_step;
  logic                    dec_step;

  assign in_edit = (state == EDIT);

  // Both keys held cancel each other; outside EDIT the repeaters stay idle,
  // and a field change restarts the initial hold delay.
  assign rep_clr = ~in_edit | (inc_lvl & dec_lvl) | sel_p;

  key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_inc_rep (
    .clk    (clk),
    .rst_n  (rst_n),
    .lvl    (inc_lvl),
    .clr    (rep_clr),
    .step_p (inc_step)
  );

  key_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dec_rep (
    .clk    (clk),
    .rst_n  (rst_n),
    .lvl    (dec_lvl),
    .clr    (rep_clr),
    .step_p (dec_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      field_idx <= '0;
      set_val   <= '0;
      tcnt      <= '0;
      timeout_p <= 1'b0;
    end else begin
      state     <= state_nx;
      field_idx <= field_idx_nx;
      set_val   <= set_val_nx;
      tcnt      <= tcnt_nx;
      timeout_p <= timeout_nx;
    end
  end

  // One event per EDIT cycle: set > cancel > sel > step > timeout.
  always_comb begin
    state_nx     = state;
    field_idx_nx = field_idx;
    set_val_nx   = set_val;
    tcnt_nx      = tcnt;
    timeout_nx   = 1'b0;
    case (state)
      RUN: begin
        tcnt_nx = '0;
        if (set_p) begin
          state_nx     = EDIT;
          set_val_nx   = cur_val;
          field_idx_nx = '0;
        end
      end
      EDIT: begin
        tcnt_nx = '0;
        if (set_p) begin
          state_nx = COMMIT;
        end else if (cancel_p) begin
          state_nx = RUN;
        end else if (sel_p) begin
          field_idx_nx = (field_idx == FW'(NUM_FIELDS - 1)) ? '0 : field_idx + 1'b1;
        end else if (inc_step || dec_step) begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            if (field_idx == FW'(i)) begin
              set_val_nx[8*i +: 8] = inc_step
                ? bcd_step_inc(set_val[8*i +: 8], FIELD_MIN[8*i +: 8], FIELD_MAX[8*i +: 8])
                : bcd_step_dec(set_val[8*i +: 8], FIELD_MIN[8*i +: 8], FIELD_MAX[8*i +: 8]);
            end
          end
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          state_nx   = RUN;
          timeout_nx = 1'b1;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      COMMIT: begin
        state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  assign set_en   = (state == EDIT) || (state == COMMIT);
  assign set_load = (state == COMMIT);

  always_comb begin
    blink_mask = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (in_edit && (field_idx == FW'(i))) blink_mask[i] = 1'b1;
    end
  end

endmodule
